dll_delay_ctrl: RTL

Digital delay-line controller for the FMDLL loop; consumes the phase-detector comparison bit `COMP` and produces the 10-bit delay code `Q` that drives the delay line. Acquires the code with a 10-step successive-approximation (SAR) search, then switches to ±1 tracking and reports lock. Sits directly downstream of the phase detector and upstream of the delay-line decoder.

---
 rtl/fmdll_pkg.sv | 21 ++
 rtl/dll_lock_detect.sv | 87 ++++++++
 rtl/dll_delay_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/fmdll_pkg.sv
// Shared definitions for the FMDLL delay-line controller.
//   QW_DEF      : default delay-code width
//   MIDSCALE    : SAR starting code for the default width
//   dll_state_e : controller mode (SAR acquisition / TRACK)
//   step_dir_e  : direction of a TRACK step (UP = longer delay, DN = shorter)
package fmdll_pkg;

  localparam int QW_DEF = 10;
  localparam logic [QW_DEF-1:0] MIDSCALE = {1'b1, {(QW_DEF-1){1'b0}}};

  typedef enum logic {
    ST_SAR   = 1'b0,
    ST_TRACK = 1'b1
  } dll_state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } step_dir_e;

endpackage

// File: rtl/dll_lock_detect.sv
// Lock detector for the TRACK phase of the delay-line controller.
// Counts consecutive direction reversals and consecutive same-direction
// steps; raises lock after LOCK_CNT reversals, drops it after LOSS_RUN
// steps in one direction.
//   clk   : controller clock
//   rst   : asynchronous active-high reset
//   clear : synchronous clear of counters, history and lock
//   step  : one TRACK step taken this cycle
//   dir   : direction of that step
//   lock  : registered lock flag
module dll_lock_detect
  import fmdll_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_RUN = 3
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      clear,
  input  logic      step,
  input  step_dir_e dir,
  output logic      lock
);

  localparam int CW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(LOSS_RUN + 1);

  logic          have_prev_reg, have_prev_next;
  step_dir_e     prev_dir_reg, prev_dir_next;
  logic [CW-1:0] rev_cnt_reg, rev_cnt_next;
  logic [RW-1:0] run_cnt_reg, run_cnt_next;
  logic          lock_reg, lock_next;

  always_comb begin
    have_prev_next = have_prev_reg;
    prev_dir_next  = prev_dir_reg;
    rev_cnt_next   = rev_cnt_reg;
    run_cnt_next   = run_cnt_reg;
    lock_next      = lock_reg;
    if (clear) begin
      have_prev_next = 1'b0;
      prev_dir_next  = DIR_UP;
      rev_cnt_next   = '0;
      run_cnt_next   = '0;
      lock_next      = 1'b0;
    end else if (step) begin
      have_prev_next = 1'b1;
      prev_dir_next  = dir;
      // The very first step has no history, so it starts a run.
      if (have_prev_reg && (dir != prev_dir_reg)) begin
        rev_cnt_next = (rev_cnt_reg >= CW'(LOCK_CNT)) ? rev_cnt_reg : rev_cnt_reg + 1'b1;
        run_cnt_next = RW'(1);
      end else begin
        rev_cnt_next = '0;
        run_cnt_next = run_cnt_reg + 1'b1;
      end
      // A long run means the loop has walked away: drop lock and start over,
      // keeping the last direction so the next step can still be a reversal.
      if (run_cnt_next >= RW'(LOSS_RUN)) begin
        lock_next    = 1'b0;
        rev_cnt_next = '0;
        run_cnt_next = '0;
      end else if (rev_cnt_next >= CW'(LOCK_CNT)) begin
        lock_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_prev_reg <= 1'b0;
      prev_dir_reg  <= DIR_UP;
      rev_cnt_reg   <= '0;
      run_cnt_reg   <= '0;
      lock_reg      <= 1'b0;
    end else begin
      have_prev_reg <= have_prev_next;
      prev_dir_reg  <= prev_dir_next;
      rev_cnt_reg   <= rev_cnt_next;
      run_cnt_reg   <= run_cnt_next;
      lock_reg      <= lock_next;
    end
  end

  assign lock = lock_reg;

endmodule

// File: rtl/dll_delay_ctrl.sv
// FMDLL delay-line controller. Acquires the delay code with a binary
// (SAR) search driven by the phase-detector bit, then tracks by +/-1 steps
// and reports lock. After every code change SETTLE qualified comparisons
// are discarded so the delay line and detector can settle.
//   clk_ext    : controller clock
//   Reset_CTRL : asynchronous active-high reset
//   COMP       : phase-detector result (1 = delay too long)
//   COMP_valid : one-cycle strobe qualifying COMP
//   Restart    : synchronous pulse, re-runs acquisition from midscale
//   Q          : registered delay code
//   Lock       : registered lock flag
//   Busy       : high while acquiring (SAR)
module dll_delay_ctrl
  import fmdll_pkg::*;
#(
  parameter int QW       = QW_DEF,
  parameter int SETTLE   = 2,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_RUN = 3
) (
  input  logic          clk_ext,
  input  logic          Reset_CTRL,
  input  logic          COMP,
  input  logic          COMP_valid,
  input  logic          Restart,
  output logic [QW-1:0] Q,
  output logic          Lock,
  output logic          Busy
);

  localparam int IW = (QW > 1) ? $clog2(QW) : 1;
  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [QW-1:0] MID_CODE = {1'b1, {(QW-1){1'b0}}};
  localparam logic [QW-1:0] MAX_CODE = {QW{1'b1}};

  dll_state_e    state_reg, state_next;
  logic [QW-1:0] q_reg, q_next;
  logic [IW-1:0] idx_reg, idx_next;
  logic [SW-1:0] settle_reg, settle_next;
  logic          busy_reg, busy_next;

  logic          step;
  step_dir_e     step_dir;
  logic          lock_clear;
  logic [QW-1:0] q_sar;

  // SAR decision for every bit in parallel: the bit under test is kept only
  // when the delay was not too long, the next lower bit becomes the new trial.
  genvar gi;
  generate
    for (gi = 0; gi < QW; gi++) begin : g_sar_bit
      assign q_sar[gi] = (IW'(gi) == idx_reg)                   ? (q_reg[gi] & ~COMP) :
                         ((IW+1)'(gi + 1) == {1'b0, idx_reg})   ? 1'b1 :
                                                                  q_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next  = state_reg;
    q_next      = q_reg;
    idx_next    = idx_reg;
    settle_next = settle_reg;
    busy_next   = busy_reg;
    step        = 1'b0;
    step_dir    = DIR_UP;
    lock_clear  = 1'b0;

    if (Restart) begin
      // Any coincident strobe is dropped.
      state_next  = ST_SAR;
      q_next      = MID_CODE;
      idx_next    = IW'(QW - 1);
      settle_next = SW'(SETTLE);
      busy_next   = 1'b1;
      lock_clear  = 1'b1;
    end else if (COMP_valid) begin
      if (settle_reg != '0) begin
        settle_next = settle_reg - 1'b1;
      end else begin
        if (state_reg == ST_SAR) begin
          q_next = q_sar;
          if (idx_reg == '0) begin
            state_next = ST_TRACK;
            busy_next  = 1'b0;
          end else begin
            idx_next = idx_reg - 1'b1;
          end
        end else begin
          step = 1'b1;
          if (COMP) begin
            step_dir = DIR_DN;
            q_next   = (q_reg == '0) ? q_reg : q_reg - 1'b1;
          end else begin
            step_dir = DIR_UP;
            q_next   = (q_reg == MAX_CODE) ? q_reg : q_reg + 1'b1;
          end
        end
        // Only a real code change disturbs the loop; a saturated step or an
        // unchanged final SAR bit leaves the next strobe usable at once.
        if (q_next != q_reg) begin
          settle_next = SW'(SETTLE);
        end
      end
    end
  end

  always_ff @(posedge clk_ext or posedge Reset_CTRL) begin
    if (Reset_CTRL) begin
      state_reg  <= ST_SAR;
      q_reg      <= MID_CODE;
      idx_reg    <= IW'(QW - 1);
      settle_reg <= SW'(SETTLE);
      busy_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      q_reg      <= q_next;
      idx_reg    <= idx_next;
      settle_reg <= settle_next;
      busy_reg   <= busy_next;
    end
  end

  dll_lock_detect #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_RUN (LOSS_RUN)
  ) u_lock_detect (
    .clk   (clk_ext),
    .rst   (Reset_CTRL),
    .clear (lock_clear),
    .step  (step),
    .dir   (step_dir),
    .lock  (Lock)
  );

  assign Q    = q_reg;
  assign Busy = busy_reg;

endmodule
